md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide controller for the E stage of the five-stage MIPS pipeline, running beside the single-cycle ALU. It latches operands on an issue, holds `busy` for a fixed operation latency so the hazard controller can stall HI/LO consumers, and commits results to the HI/LO architectural registers. It also serves MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
- `MULT_LAT`, 5, cycles `busy` stays high after a MULT/MULTU issue (legal 1..15)
- `DIV_LAT`, 10, cycles `busy` stays high after a DIV/DIVU issue (legal 1..15)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `mdValid`  in  1  E-stage instruction is an MD-class op, not flushed, not stalled
- `mdOp`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- `srcA`  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data)
- `srcB`  in  32  rt operand (divisor / multiplier)
- `hiLoSel`  in  1  read select for `mdRes`: 1 HI, 0 LO
- `busy`  out  1  operation in flight (registered)
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `mdRes`  out  32  combinational `hiLoSel ? hi : lo` (MFHI/MFLO data)

## Operation
- State: `cnt` (4 bit), `hi`, `lo`, pending `pHi`, `pLo`, `pWr` (commit enable).
- IDLE (`cnt`==0) + `mdValid` + start op (1-4): at the edge, compute result into `pHi`/`pLo`, load `cnt` with MULT_LAT or DIV_LAT, set `pWr`.
- BUSY (`cnt`!=0): `cnt` decrements each edge; on the 1->0 edge, if `pWr`, `hi<=pHi`, `lo<=pLo`.
- MULT: signed 32x32 -> 64; `hi`=[63:32], `lo`=[31:0]. MULTU unsigned.
- DIV: `lo`=quotient truncated toward zero, `hi`=remainder with sign of dividend. DIVU unsigned.
- Divisor 0 (DIV/DIVU): `pWr`=0; `busy` still runs full DIV_LAT; HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0 (wrap, no trap).
- MTHI/MTLO in IDLE with `mdValid`: `hi`/`lo` <= `srcA` at that edge; `busy` stays 0.
- Any op with `mdValid` while BUSY is ignored (controller guarantees stall; the block must not corrupt state).
- `busy` = (`cnt` != 0), from a flop; no combinational path from inputs.
- Reset (any time, including mid-operation): `cnt`=0, `busy`=0, `hi`=0, `lo`=0, `pWr`=0, `pHi`=`pLo`=0; in-flight result is discarded.

## Timing
- Issue sampled at edge T; `busy` high from T through edge T+LAT-1, low after edge T+LAT.
- HI/LO visible after edge T+LAT; `mdRes` reflects them the same cycle (no extra latency).
- Back-to-back: a new start op may be issued in the first cycle `busy` is low (edge T+LAT+1 earliest sample).
- MTHI/MTLO: written at issue edge; `mdRes` shows new value next cycle.
- Controller stall rule supported: stall D-stage MD op while `busy` or while E holds a start op with `mdValid`.

## Configuration
- `MD_UNIT_DIV_EN` defined: DIV/DIVU implemented as above.
- Not defined: no divider logic; ops 3/4 are treated as NONE (no `busy`, HI/LO unchanged); MULT/MULTU/MTHI/MTLO unaffected.

## Test plan
- Reset, then MULT srcA=0xFFFFFFFE (-2), srcB=3 -> `busy` high 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 5 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV -7 / 2 -> `busy` 10 cycles; `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF; DIVU 7/0 -> `busy` 10 cycles, HI/LO unchanged.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> `hi`/`lo` hold those; `mdRes` tracks `hiLoSel`; `busy` never asserts.
- MULT issued, MTLO 0xAAAA5555 presented with `mdValid` during `busy` -> ignored; final `lo` is the MULT result.
- DIV issued, `rst_n` pulsed low at cycle 4 -> `busy`=0, `hi`=`lo`=0 immediately; no commit after release; with `MD_UNIT_DIV_EN` undefined, DIV 8/2 -> `busy` stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide controller with HI/LO registers for the MIPS E stage.
// Define MD_UNIT_DIV_EN to build the DIV/DIVU datapath; without it those ops act as NONE.
module md_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdValid,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        hiLoSel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdRes
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  md_op_e      w_op;
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_p_hi, r_p_lo;
  logic        r_p_wr;

  logic        w_start;
  logic [3:0]  w_lat;
  logic [31:0] w_p_hi, w_p_lo;
  logic        w_p_wr;
  logic        w_idle;

  logic signed [63:0] w_smul;
  logic [63:0]        w_umul;

  assign w_op   = md_op_e'(mdOp);
  assign w_idle = (r_cnt == 4'd0);

  assign w_smul = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign w_umul = {32'd0, srcA} * {32'd0, srcB};

`ifdef MD_UNIT_DIV_EN
  logic               w_ovf;
  logic signed [31:0] w_sdiv_a, w_sdiv_b, w_squot, w_srem;
  logic [31:0]        w_udiv_b, w_uquot, w_urem;

  // Divisor forced to 1 on /0 (result discarded) and on MIN/-1, where
  // MIN/1 yields exactly the wrapped quotient 0x80000000 with remainder 0.
  assign w_ovf    = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);
  assign w_sdiv_a = $signed(srcA);
  assign w_sdiv_b = ((srcB == 32'd0) || w_ovf) ? 32'sd1 : $signed(srcB);
  assign w_squot  = w_sdiv_a / w_sdiv_b;
  assign w_srem   = w_sdiv_a % w_sdiv_b;
  assign w_udiv_b = (srcB == 32'd0) ? 32'd1 : srcB;
  assign w_uquot  = srcA / w_udiv_b;
  assign w_urem   = srcA % w_udiv_b;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    w_start = 1'b0;
    w_lat   = 4'd0;
    w_p_hi  = 32'd0;
    w_p_lo  = 32'd0;
    w_p_wr  = 1'b0;
    case (w_op)
      OP_MULT: begin
        w_start = 1'b1;
        w_lat   = 4'(MULT_LAT);
        w_p_hi  = w_smul[63:32];
        w_p_lo  = w_smul[31:0];
        w_p_wr  = 1'b1;
      end
      OP_MULTU: begin
        w_start = 1'b1;
        w_lat   = 4'(MULT_LAT);
        w_p_hi  = w_umul[63:32];
        w_p_lo  = w_umul[31:0];
        w_p_wr  = 1'b1;
      end
`ifdef MD_UNIT_DIV_EN
      OP_DIV: begin
        w_start = 1'b1;
        w_lat   = 4'(DIV_LAT);
        w_p_hi  = w_srem;
        w_p_lo  = w_squot;
        w_p_wr  = (srcB != 32'd0);
      end
      OP_DIVU: begin
        w_start = 1'b1;
        w_lat   = 4'(DIV_LAT);
        w_p_hi  = w_urem;
        w_p_lo  = w_uquot;
        w_p_wr  = (srcB != 32'd0);
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: pending result registers are reset too, so an aborted operation can never commit later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 4'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_p_hi <= 32'd0;
      r_p_lo <= 32'd0;
      r_p_wr <= 1'b0;
    end else if (!w_idle) begin
      // Any op arriving while busy is dropped; only the countdown advances.
      r_cnt <= r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        r_p_wr <= 1'b0;
        if (r_p_wr) begin
          r_hi <= r_p_hi;
          r_lo <= r_p_lo;
        end
      end
    end else if (mdValid) begin
      if (w_start) begin
        r_cnt  <= w_lat;
        r_p_hi <= w_p_hi;
        r_p_lo <= w_p_lo;
        r_p_wr <= w_p_wr;
      end else if (w_op == OP_MTHI) begin
        r_hi <= srcA;
      end else if (w_op == OP_MTLO) begin
        r_lo <= srcA;
      end
    end
  end

  assign busy  = !w_idle;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign mdRes = hiLoSel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit; DIV expectations follow MD_UNIT_DIV_EN.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                         OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5,
                         OP_MTLO = 3'd6, OP_RSVD = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mdValid;
  logic [2:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        hiLoSel;
  logic        busy;
  logic [31:0] hi, lo, mdRes;

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mdValid(mdValid), .mdOp(mdOp),
    .srcA(srcA), .srcB(srcB), .hiLoSel(hiLoSel),
    .busy(busy), .hi(hi), .lo(lo), .mdRes(mdRes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          n_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n_busy, input logic [31:0] eh, input logic [31:0] el,
                         input string name);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.n_busy = n_busy;
    v.exp_hi = eh; v.exp_lo = el; v.name = name;
    vecs.push_back(v);
  endtask

  // Issue one op, count busy cycles (bounded), check HI/LO hold during busy and final values.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n_busy, input logic [31:0] eh, input logic [31:0] el,
                        input string name);
    int n;
    @(negedge clk);
    mdValid = 1'b1; mdOp = op; srcA = a; srcB = b;
    @(posedge clk); #1;
    mdValid = 1'b0; mdOp = OP_NONE;
    n = 0;
    while (busy && n < 40) begin
      check({name, " hold hi"}, hi, m_hi);
      check({name, " hold lo"}, lo, m_lo);
      n++;
      @(posedge clk); #1;
    end
    check({name, " busy cycles"}, 32'(n), 32'(n_busy));
    hiLoSel = 1'b1; #1;
    check({name, " hi"}, hi, eh);
    check({name, " mdRes(hi)"}, mdRes, eh);
    hiLoSel = 1'b0; #1;
    check({name, " lo"}, lo, el);
    check({name, " mdRes(lo)"}, mdRes, el);
    m_hi = eh;
    m_lo = el;
  endtask

  initial begin
    logic [2:0] long_op;
    int         long_lat;

    rst_n = 1'b0; mdValid = 1'b0; mdOp = OP_NONE;
    srcA = 32'd0; srcB = 32'd0; hiLoSel = 1'b0;

    add_vec(OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, MULT_LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult -2*3");
    add_vec(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'hFFFF_FFFE, 32'h0000_0001, "multu max*max");
    add_vec(OP_MULT,  32'h0001_0000, 32'h0001_0000, MULT_LAT, 32'h0000_0001, 32'h0000_0000, "mult 2^16*2^16");
    add_vec(OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, MULT_LAT, 32'hC000_0000, 32'h8000_0000, "mult max*min");
    add_vec(OP_MTHI,  32'h1234_5678, 32'h0,         0,        32'h1234_5678, 32'h8000_0000, "mthi");
    add_vec(OP_MTLO,  32'h9ABC_DEF0, 32'h0,         0,        32'h1234_5678, 32'h9ABC_DEF0, "mtlo");
    add_vec(OP_RSVD,  32'hDEAD_BEEF, 32'h1,         0,        32'h1234_5678, 32'h9ABC_DEF0, "reserved op");
    add_vec(OP_NONE,  32'hDEAD_BEEF, 32'h1,         0,        32'h1234_5678, 32'h9ABC_DEF0, "none op");
`ifdef MD_UNIT_DIV_EN
    add_vec(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    add_vec(OP_DIVU,  32'h0000_0007, 32'h0000_0000, DIV_LAT,  32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu 7/0");
    add_vec(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,  32'h0000_0000, 32'h8000_0000, "div min/-1");
    add_vec(OP_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, DIV_LAT,  32'h0000_0005, 32'h1999_9999, "divu max/10");
    add_vec(OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT,  32'h0000_0001, 32'hFFFF_FFFD, "div 7/-2");
`else
    add_vec(OP_DIV,   32'h0000_0008, 32'h0000_0002, 0,        32'h1234_5678, 32'h9ABC_DEF0, "div 8/2 disabled");
    add_vec(OP_DIVU,  32'h0000_0007, 32'h0000_0000, 0,        32'h1234_5678, 32'h9ABC_DEF0, "divu 7/0 disabled");
`endif

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);
    check("reset mdRes", mdRes, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].n_busy,
             vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);

    // Ops presented while busy must be ignored, and busy timing must be unaffected.
    @(negedge clk);
    mdValid = 1'b1; mdOp = OP_MULT; srcA = 32'd3; srcB = 32'd4;
    @(posedge clk); #1;
    check("ignore busy @T", 32'(busy), 32'd1);
    for (int i = 1; i < MULT_LAT; i++) begin
      mdValid = 1'b1;
      if (i < 4) begin mdOp = OP_MTLO; srcA = 32'hAAAA_5555; end
      else begin mdOp = OP_MULT; srcA = 32'd100; srcB = 32'd100; end
      @(posedge clk); #1;
      check($sformatf("ignore busy @T+%0d", i), 32'(busy), 32'd1);
      check($sformatf("ignore lo @T+%0d", i), lo, m_lo);
    end
    mdValid = 1'b0; mdOp = OP_NONE;
    @(posedge clk); #1;
    check("ignore busy done", 32'(busy), 32'd0);
    check("ignore hi", hi, 32'd0);
    check("ignore lo", lo, 32'd12);
    m_hi = 32'd0; m_lo = 32'd12;

    // Issue in the first idle cycle after busy drops.
    run_op(OP_MULTU, 32'd5, 32'd6, MULT_LAT, 32'd0, 32'd30, "back-to-back multu");
    run_op(OP_MTHI, 32'h0BAD_F00D, 32'd0, 0, 32'h0BAD_F00D, 32'd30, "mthi before reset");

    // Reset in the middle of a long operation discards it.
`ifdef MD_UNIT_DIV_EN
    long_op = OP_DIV; long_lat = DIV_LAT;
`else
    long_op = OP_MULT; long_lat = MULT_LAT;
`endif
    @(negedge clk);
    mdValid = 1'b1; mdOp = long_op; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    mdValid = 1'b0; mdOp = OP_NONE;
    repeat (3) @(posedge clk);
    #1;
    check("mid-op busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0; #1;
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset hi", hi, 32'd0);
    check("mid-op reset lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (long_lat + 3) @(posedge clk);
    #1;
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset hi", hi, 32'd0);
    check("post-reset lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, 32'd0, 32'd1, "mult after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
